lc_mem_responder: RTL and testbench

LC_MEM_RESPONDER -- requirements
Module: lc_mem_responder

---
 rtl/mem_types_pkg.sv | 18 +
 rtl/lc_resp_fifo.sv | 53 +++++
 rtl/lc_mem_responder.sv | 132 +++++++++++++
 tb/tb_lc_mem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_types_pkg.sv
// Shared types for the lower-cache memory responder.
// Entry fields are sized for the widest supported address.
package mem_types_pkg;

  localparam int PADDR_MAX = 64;

  typedef struct packed {
    logic [PADDR_MAX-1:0] paddr;
    logic [63:0]          data;
  } resp_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_e;

endpackage

// File: rtl/lc_resp_fifo.sv
// Pending-read queue for the memory responder.
// DEPTH must be a power of two, at least 2.
module lc_resp_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk_in,
  input  logic   rst_N_in,
  input  logic   enq,
  input  entry_t enq_data,
  input  logic   deq,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_enq;
  logic            do_deq;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/lc_mem_responder.sv
// Backing-store responder for the L1 lower-cache port.
// Reads are queued with their data and answered after a fixed delay.
module lc_mem_responder
  import mem_types_pkg::*;
#(
  parameter int PADDR_BITS  = 22,
  parameter int MEM_WORDS   = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  cs_N_in,
  input  logic                  hc_valid_in,
  output logic                  hc_ready_out,
  input  logic [PADDR_BITS-1:0] hc_addr_in,
  input  logic [63:0]           hc_value_in,
  input  logic                  hc_we_in,
  output logic                  hc_valid_out,
  input  logic                  hc_ready_in,
  output logic [PADDR_BITS-1:0] hc_addr_out,
  output logic [63:0]           hc_value_out
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [63:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic             q_full;
  logic             q_empty;
  logic             deq;
  resp_entry_t      enq_entry;
  resp_entry_t      head;

  resp_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             popped, popped_n;

  logic             unused_bits;

  assign idx          = hc_addr_in[3 +: IDX_W];
  assign hc_ready_out = rst_N_in && !cs_N_in && !q_full;
  assign accept       = hc_valid_in && hc_ready_out;
  assign wr_en        = accept && hc_we_in;
  assign rd_en        = accept && !hc_we_in;
  assign unused_bits  = ^{hc_addr_in, head};

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= hc_value_in;
    end
  end

  // Data is captured at accept, so later writes never leak into it.
  always_comb begin
    enq_entry = '0;
    enq_entry.paddr[PADDR_BITS-1:0] = hc_addr_in;
    enq_entry.data = mem[idx];
  end

  lc_resp_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (resp_entry_t)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_N_in (rst_N_in),
    .enq      (rd_en),
    .enq_data (enq_entry),
    .deq      (deq),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      popped <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      popped <= popped_n;
    end
  end

  // One idle bubble after each handshake separates consecutive answers.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    popped_n = 1'b0;
    deq      = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (!q_empty && !popped) begin
          state_n = ST_WAIT;
          cnt_n   = CNT_W'(LATENCY - 1);
        end
      end
      (state == ST_WAIT): begin
        if (cnt == '0) state_n = ST_RESP;
        else           cnt_n   = cnt - 1'b1;
      end
      (state == ST_RESP): begin
        if (hc_ready_in) begin
          deq      = 1'b1;
          popped_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    hc_valid_out = 1'b0;
    hc_addr_out  = '0;
    hc_value_out = '0;
    if (state == ST_RESP) begin
      hc_valid_out = 1'b1;
      hc_addr_out  = head.paddr[PADDR_BITS-1:0];
      hc_value_out = head.data;
    end
  end

endmodule

// File: tb/tb_lc_mem_responder.sv
// Directed self-checking bench for lc_mem_responder.
module tb_lc_mem_responder;

  localparam int LAT = 4;

  logic        clk_in = 1'b0;
  logic        rst_N_in;
  logic        cs_N_in;
  logic        hc_valid_in;
  logic        hc_ready_out;
  logic [21:0] hc_addr_in;
  logic [63:0] hc_value_in;
  logic        hc_we_in;
  logic        hc_valid_out;
  logic        hc_ready_in;
  logic [21:0] hc_addr_out;
  logic [63:0] hc_value_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int hs    = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (hc_valid_out && hc_ready_in) hs <= hs + 1;
  end

  lc_mem_responder #(
    .PADDR_BITS  (22),
    .MEM_WORDS   (256),
    .LATENCY     (LAT),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_N_in     (rst_N_in),
    .cs_N_in      (cs_N_in),
    .hc_valid_in  (hc_valid_in),
    .hc_ready_out (hc_ready_out),
    .hc_addr_in   (hc_addr_in),
    .hc_value_in  (hc_value_in),
    .hc_we_in     (hc_we_in),
    .hc_valid_out (hc_valid_out),
    .hc_ready_in  (hc_ready_in),
    .hc_addr_out  (hc_addr_out),
    .hc_value_out (hc_value_out)
  );

  task automatic issue(input logic we, input logic [21:0] a,
                       input logic [63:0] v, output bit acc);
    hc_valid_in = 1'b1;
    hc_we_in    = we;
    hc_addr_in  = a;
    hc_value_in = v;
    acc = hc_ready_out;
    @(posedge clk_in); #1;
    hc_valid_in = 1'b0;
    hc_we_in    = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (hc_valid_out) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_in); #1;
    end
  endtask

  task automatic fetch(input logic [21:0] a, output logic [63:0] v,
                       output bit seen);
    bit acc;
    hc_ready_in = 1'b1;
    issue(1'b0, a, 64'd0, acc);
    wait_valid(LAT + 8, seen);
    v = hc_value_out;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset;
    rst_N_in = 1'b1; cs_N_in = 1'b0; hc_valid_in = 1'b0;
    hc_we_in = 1'b0; hc_addr_in = '0; hc_value_in = '0;
    hc_ready_in = 1'b1;
    #1 rst_N_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    tests++;
    if (hc_valid_out !== 1'b0 || hc_addr_out !== '0 || hc_value_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b addr=%h value=%h, want 0/0/0",
               hc_valid_out, hc_addr_out, hc_value_out);
    end
    tests++;
    if (hc_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0", hc_ready_out);
    end
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;
    tests++;
    if (hc_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b want 1", hc_ready_out);
    end
  endtask

  task automatic test_write_read;
    bit acc1, acc2;
    hc_ready_in = 1'b1;
    issue(1'b1, 22'h000108, 64'hDEAD_BEEF, acc1);
    issue(1'b0, 22'h000108, 64'd0, acc2);
    tests++;
    if (!(acc1 && acc2)) begin
      fails++;
      $display("FAIL wr_rd_accept: got %b%b want 11", acc1, acc2);
    end
    for (int i = 1; i <= LAT + 1; i++) begin
      @(posedge clk_in); #1;
      tests++;
      if (hc_valid_out !== (i == LAT + 1)) begin
        fails++;
        $display("FAIL latency_edge%0d: valid=%b want %b",
                 i, hc_valid_out, (i == LAT + 1));
      end
    end
    tests++;
    if (hc_value_out !== 64'hDEAD_BEEF || hc_addr_out !== 22'h000108) begin
      fails++;
      $display("FAIL wr_rd_data: addr=%h value=%h want 000108/deadbeef",
               hc_addr_out, hc_value_out);
    end
    @(posedge clk_in); #1;
    tests++;
    if (hc_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL valid_drop: got %b want 0", hc_valid_out);
    end
  endtask

  task automatic test_stall;
    bit acc, seen, bad;
    int h0;
    logic [63:0] exp = 64'h1234_5678_9ABC_DEF0;
    issue(1'b1, 22'h000040, exp, acc);
    hc_ready_in = 1'b0;
    issue(1'b0, 22'h000040, 64'd0, acc);
    wait_valid(LAT + 4, seen);
    h0 = hs;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL stall_valid: no response, want one");
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      tests++;
      if (hc_valid_out !== 1'b1 || hc_value_out !== exp ||
          hc_addr_out !== 22'h000040) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h value=%h want 1/000040/%h",
                 i, hc_valid_out, hc_addr_out, hc_value_out, exp);
      end
    end
    hc_ready_in = 1'b1;
    @(posedge clk_in); #1;
    bad = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (hc_valid_out) bad = 1'b1;
      @(posedge clk_in); #1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL stall_empty: extra response seen, want none");
    end
    tests++;
    if (hs - h0 !== 1) begin
      fails++;
      $display("FAIL stall_handshakes: got %0d want 1", hs - h0);
    end
  endtask

  task automatic test_full;
    bit acc, all_acc, seen, bad;
    int m, t1;
    logic [63:0] v;
    for (int k = 0; k < 4; k++)
      issue(1'b1, 22'h000200 + 22'(8 * k), 64'(11 * (k + 1)), acc);
    hc_ready_in = 1'b0;
    all_acc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 22'h000200 + 22'(8 * k), 64'd0, acc);
      all_acc = all_acc && acc;
    end
    tests++;
    if (!all_acc) begin
      fails++;
      $display("FAIL full_accept4: some read refused, want all accepted");
    end
    hc_valid_in = 1'b1; hc_addr_in = 22'h000220;
    bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (hc_ready_out) bad = 1'b1;
      @(posedge clk_in); #1;
    end
    hc_we_in = 1'b1; hc_addr_in = 22'h000228; hc_value_in = 64'd99;
    if (hc_ready_out) bad = 1'b1;
    @(posedge clk_in); #1;
    hc_valid_in = 1'b0; hc_we_in = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL full_ready: ready_out was 1 while full, want 0");
    end
    hc_ready_in = 1'b1;
    m = 0; t1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(4 * LAT + 10, seen);
      if (k == 1) t1 = cyc;
      tests++;
      if (!seen || hc_addr_out !== 22'h000200 + 22'(8 * k) ||
          hc_value_out !== 64'(11 * (k + 1))) begin
        fails++;
        $display("FAIL full_order%0d: seen=%b addr=%h value=%0d want %h/%0d",
                 k, seen, hc_addr_out, hc_value_out,
                 22'h000200 + 22'(8 * k), 11 * (k + 1));
      end
      @(posedge clk_in); #1;
      if (k == 0) m = cyc;
    end
    tests++;
    if (t1 - m !== LAT + 2) begin
      fails++;
      $display("FAIL back_to_back_gap: got %0d want %0d", t1 - m, LAT + 2);
    end
    bad = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (hc_valid_out) bad = 1'b1;
      @(posedge clk_in); #1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL full_fifth: stalled read answered, want none");
    end
    fetch(22'h000228, v, seen);
    tests++;
    if (!seen || v !== 64'd0) begin
      fails++;
      $display("FAIL full_write_refused: seen=%b value=%0d want 1/0", seen, v);
    end
  endtask

  task automatic test_write_after_read;
    bit acc, seen;
    logic [63:0] v;
    hc_ready_in = 1'b1;
    issue(1'b0, 22'h000080, 64'd0, acc);
    issue(1'b1, 22'h000080, 64'd7, acc);
    wait_valid(LAT + 4, seen);
    tests++;
    if (!seen || hc_value_out !== 64'd0 || hc_addr_out !== 22'h000080) begin
      fails++;
      $display("FAIL war_old_data: seen=%b addr=%h value=%0d want 1/000080/0",
               seen, hc_addr_out, hc_value_out);
    end
    @(posedge clk_in); #1;
    fetch(22'h000080, v, seen);
    tests++;
    if (!seen || v !== 64'd7) begin
      fails++;
      $display("FAIL war_new_data: seen=%b value=%0d want 1/7", seen, v);
    end
  endtask

  task automatic test_reset_mid;
    bit acc, seen, bad;
    logic [63:0] v;
    hc_ready_in = 1'b1;
    issue(1'b1, 22'h000300, 64'h55, acc);
    issue(1'b0, 22'h000300, 64'd0, acc);
    repeat (2) @(posedge clk_in);
    #3 rst_N_in = 1'b0;
    #1;
    tests++;
    if (hc_valid_out !== 1'b0 || hc_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: valid=%b ready=%b want 0/0",
               hc_valid_out, hc_ready_out);
    end
    @(posedge clk_in); #3;
    rst_N_in = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk_in); #1;
      if (hc_valid_out) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL midreset_discard: response after reset, want none");
    end
    fetch(22'h000300, v, seen);
    tests++;
    if (!seen || v !== 64'd0) begin
      fails++;
      $display("FAIL midreset_mem: seen=%b value=%h want 1/0", seen, v);
    end
  endtask

  task automatic test_cs;
    bit acc, seen, bad;
    logic [63:0] v;
    hc_ready_in = 1'b1;
    issue(1'b1, 22'h000088, 64'hABC, acc);
    issue(1'b0, 22'h000088, 64'd0, acc);
    cs_N_in = 1'b1;
    hc_valid_in = 1'b1; hc_we_in = 1'b1;
    hc_addr_in = 22'h000090; hc_value_in = 64'd5;
    #1;
    tests++;
    if (hc_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL cs_ready: got %b want 0", hc_ready_out);
    end
    wait_valid(LAT + 4, seen);
    tests++;
    if (!seen || hc_value_out !== 64'hABC) begin
      fails++;
      $display("FAIL cs_pending: seen=%b value=%h want 1/abc",
               seen, hc_value_out);
    end
    @(posedge clk_in); #1;
    cs_N_in = 1'b0; hc_valid_in = 1'b0; hc_we_in = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (hc_valid_out) bad = 1'b1;
      @(posedge clk_in); #1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL cs_no_accept: extra response, want none");
    end
    fetch(22'h000090, v, seen);
    tests++;
    if (!seen || v !== 64'd0) begin
      fails++;
      $display("FAIL cs_write_blocked: seen=%b value=%0d want 1/0", seen, v);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_stall;
    test_full;
    test_write_after_read;
    test_reset_mid;
    test_cs;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
